// File: rtl/clk_gate_pkg.sv
// Shared types and default parameters for the ICG enable controller.
// State encoding matches the debug view exposed on state_o.
package clk_gate_pkg;

    typedef enum logic [2:0] {
        ON   = 3'd0,
        QREQ = 3'd1,
        OFF  = 3'd2,
        WAKE = 3'd3
    } icg_state_t;

    localparam int IDLE_W_DEF   = 8;
    localparam int WAKE_CYC_DEF = 2;
    localparam int CNT_W_DEF    = 16;

endpackage

// File: rtl/icg_en_ctrl_if.sv
// Quiesce and wake handshake between the gate controller and its domain.
// master = controller side, slave = gated domain / wake requester.
interface icg_en_ctrl_if;

    logic qreq;
    logic qaccept;
    logic qdeny;
    logic wake_req;
    logic wake_ack;

    modport master (
        output qreq,
        output wake_ack,
        input  qaccept,
        input  qdeny,
        input  wake_req
    );

    modport slave (
        input  qreq,
        input  wake_ack,
        output qaccept,
        output qdeny,
        output wake_req
    );

endinterface

// File: rtl/sat_cnt.sv
// Saturating up-counter with synchronous clear.
// Clear has priority over a same-cycle increment.
module sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    // count up, stick at all-ones, clear wins
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/icg_en_ctrl.sv
// EN/SE generator for one ICG: idle-timed quiesce, gate, and wake.
// Runs on the free-running clock upstream of the gate.
module icg_en_ctrl
    import clk_gate_pkg::*;
#(
    parameter int IDLE_W   = IDLE_W_DEF,
    parameter int WAKE_CYC = WAKE_CYC_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              auto_en,
    input  logic              sw_force_on,
    input  logic [IDLE_W-1:0] idle_thresh,
    input  logic              busy,
    input  logic              scan_mode,
    input  logic              cnt_clr,
    icg_en_ctrl_if.master     qif,
    output logic              icg_en,
    output logic              icg_se,
    output logic [2:0]        state_o,
    output logic [CNT_W-1:0]  gated_cnt
);

    localparam logic [2:0] ST_ON   = ON;
    localparam logic [2:0] ST_QREQ = QREQ;
    localparam logic [2:0] ST_OFF  = OFF;
    localparam logic [2:0] ST_WAKE = WAKE;

    localparam int WW = (WAKE_CYC > 1) ? $clog2(WAKE_CYC) : 1;
    localparam logic [WW-1:0] WAKE_LAST = WW'(WAKE_CYC - 1);

    logic [2:0]        state;
    logic [IDLE_W-1:0] idle_cnt;
    logic [WW-1:0]     wake_cnt;
    logic              acked;
    logic              exit_cond;
    logic              idle_hit;
    logic              wake_done;
    logic              ack_next;
    logic              in_off;

    assign exit_cond = sw_force_on | ~auto_en | (idle_thresh == '0)
                     | busy | qif.wake_req;

    // >= keeps the counter bounded if the threshold is lowered mid-count
    assign idle_hit  = idle_cnt >= (idle_thresh - IDLE_W'(1));
    assign wake_done = (state == ST_WAKE) && (wake_cnt == WAKE_LAST);
    assign ack_next  = wake_done
                     | ((state == ST_ON) & qif.wake_req & ~acked);
    assign in_off    = (state == ST_OFF);

    assign icg_se  = scan_mode;
    assign state_o = state;

    // gating FSM; icg_en and qreq are registered so EN only moves at rising edges
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_ON;
            icg_en   <= 1'b1;
            qif.qreq <= 1'b0;
            idle_cnt <= '0;
            wake_cnt <= '0;
        end else begin
            case (state)
                ST_ON: begin
                    if (exit_cond) begin
                        idle_cnt <= '0;
                    end else if (idle_hit) begin
                        state    <= ST_QREQ;
                        qif.qreq <= 1'b1;
                        idle_cnt <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + IDLE_W'(1);
                    end
                end
                ST_QREQ: begin
                    if (qif.qdeny | exit_cond) begin
                        state    <= ST_ON;
                        qif.qreq <= 1'b0;
                        idle_cnt <= '0;
                    end else if (qif.qaccept) begin
                        state  <= ST_OFF;
                        icg_en <= 1'b0;
                    end
                end
                ST_OFF: begin
                    if (exit_cond) begin
                        state    <= ST_WAKE;
                        icg_en   <= 1'b1;
                        wake_cnt <= '0;
                    end
                end
                ST_WAKE: begin
                    if (wake_done) begin
                        state    <= ST_ON;
                        qif.qreq <= 1'b0;
                        idle_cnt <= '0;
                    end else begin
                        wake_cnt <= wake_cnt + WW'(1);
                    end
                end
                default: begin
                    state    <= ST_ON;
                    icg_en   <= 1'b1;
                    qif.qreq <= 1'b0;
                    idle_cnt <= '0;
                    wake_cnt <= '0;
                end
            endcase
        end
    end

    // one ack per held wake_req; acked drops once the requester lets go
    always_ff @(posedge clk) begin
        if (rst) begin
            qif.wake_ack <= 1'b0;
            acked        <= 1'b0;
        end else begin
            qif.wake_ack <= ack_next;
            acked        <= qif.wake_req & (acked | ack_next);
        end
    end

    sat_cnt #(
        .W (CNT_W)
    ) u_gated_cnt (
        .clk (clk),
        .rst (rst),
        .inc (in_off),
        .clr (cnt_clr),
        .cnt (gated_cnt)
    );

endmodule
